// File: rtl/seq_pkg.sv
// Shared types and width helpers for the seq_player pattern-sequence player.
package seq_pkg;

    typedef enum logic [0:0] {
        PLAY   = 1'b0,
        RESYNC = 1'b1
    } seq_state_t;

    function automatic int sel_width(input int num_seq);
        return (num_seq > 1) ? $clog2(num_seq) : 1;
    endfunction

    function automatic int step_width(input int steps);
        return (steps > 1) ? $clog2(steps) : 1;
    endfunction

endpackage

// File: rtl/pb_debounce.sv
// Push-button conditioner: 2-FF synchroniser, sampled history shift register,
// level hold with hysteresis and a one-cycle rising-edge pulse.
module pb_debounce
    import seq_pkg::*;
#(
    parameter int DB_DEPTH = 8
) (
    input  logic clk_50,
    input  logic reset,
    input  logic sample_en,
    input  logic noisy,
    output logic level,
    output logic rise
);

    logic [1:0]          sync_q, sync_d;
    logic [DB_DEPTH-1:0] hist_q, hist_d;
    logic                level_q, level_d;
    logic                rise_q, rise_d;

    // Next-state: synchronise, shift on sample strobe, update held level.
    always_comb begin
        sync_d  = {sync_q[0], noisy};
        hist_d  = hist_q;
        level_d = level_q;
        if (sample_en) begin
            hist_d = {hist_q[DB_DEPTH-2:0], sync_q[1]};
        end else begin
            hist_d = hist_q;
        end
        // Level moves only on a unanimous history; mixed histories hold it.
        if (&hist_d) begin
            level_d = 1'b1;
        end else if (~|hist_d) begin
            level_d = 1'b0;
        end else begin
            level_d = level_q;
        end
        rise_d = level_d & ~level_q;
    end

    // Conditioner state registers.
    always_ff @(posedge clk_50 or negedge reset) begin
        if (!reset) begin
            sync_q  <= 2'b00;
            hist_q  <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            hist_q  <= hist_d;
            level_q <= level_d;
            rise_q  <= rise_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;

endmodule

// File: rtl/seq_player.sv
// Pattern-sequence player: debounced up/down sequence selector and step counter
// producing the pattern-ROM address. Define SEQ_WRAP_EN to wrap instead of saturate.
module seq_player
    import seq_pkg::*;
#(
    parameter  int NUM_SEQ  = 8,
    parameter  int STEPS    = 16,
    parameter  int DB_DEPTH = 8,
    parameter  int DB_DIV   = 50000,
    localparam int SW       = sel_width(NUM_SEQ),
    localparam int TW       = step_width(STEPS)
) (
    input  logic          clk_50,
    input  logic          reset,
    input  logic          pb_seq_up,
    input  logic          pb_seq_dn,
    input  logic          slow_tick,
    output logic [SW-1:0] seq_num,
    output logic [TW-1:0] step_num,
    output logic [SW+TW-1:0] rom_addr,
    output logic          seq_changed
);

    localparam int CW = $clog2(DB_DIV);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          sample_en_s;
    logic          up_evt_s, dn_evt_s;
    logic [1:0]    levels_unused;

    logic [SW-1:0] seq_q, seq_d;
    logic [TW-1:0] step_q, step_d;
    seq_state_t    state_q, state_d;
    logic          changed_q, change_s;

    // Shared debounce sample divider.
    always_comb begin
        sample_en_s = (cnt_q == CW'(DB_DIV - 1));
        if (sample_en_s) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    pb_debounce #(.DB_DEPTH(DB_DEPTH)) u_db_up (
        .clk_50    (clk_50),
        .reset     (reset),
        .sample_en (sample_en_s),
        .noisy     (pb_seq_up),
        .level     (levels_unused[0]),
        .rise      (up_evt_s)
    );

    pb_debounce #(.DB_DEPTH(DB_DEPTH)) u_db_dn (
        .clk_50    (clk_50),
        .reset     (reset),
        .sample_en (sample_en_s),
        .noisy     (pb_seq_dn),
        .level     (levels_unused[1]),
        .rise      (dn_evt_s)
    );

    // Sequence selector; simultaneous up/down cancel out.
    always_comb begin
        seq_d    = seq_q;
        change_s = 1'b0;
        if (up_evt_s && !dn_evt_s) begin
`ifdef SEQ_WRAP_EN
            seq_d    = seq_q + SW'(1);
            change_s = 1'b1;
`else
            if (seq_q != SW'(NUM_SEQ - 1)) begin
                seq_d    = seq_q + SW'(1);
                change_s = 1'b1;
            end else begin
                seq_d    = seq_q;
                change_s = 1'b0;
            end
`endif
        end else if (dn_evt_s && !up_evt_s) begin
`ifdef SEQ_WRAP_EN
            seq_d    = seq_q - SW'(1);
            change_s = 1'b1;
`else
            if (seq_q != SW'(0)) begin
                seq_d    = seq_q - SW'(1);
                change_s = 1'b1;
            end else begin
                seq_d    = seq_q;
                change_s = 1'b0;
            end
`endif
        end else begin
            seq_d    = seq_q;
            change_s = 1'b0;
        end
    end

    // Step state machine; a sequence change overrides any coincident tick.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        if (change_s) begin
            state_d = RESYNC;
            step_d  = '0;
        end else begin
            case (state_q)
                PLAY: begin
                    if (slow_tick) begin
                        step_d = step_q + TW'(1);
                    end else begin
                        step_d = step_q;
                    end
                end
                RESYNC: begin
                    if (slow_tick) begin
                        state_d = PLAY;
                    end else begin
                        state_d = RESYNC;
                    end
                end
                default: begin
                    state_d = PLAY;
                    step_d  = '0;
                end
            endcase
        end
    end

    // Player state registers.
    always_ff @(posedge clk_50 or negedge reset) begin
        if (!reset) begin
            cnt_q     <= '0;
            seq_q     <= '0;
            step_q    <= '0;
            state_q   <= PLAY;
            changed_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            seq_q     <= seq_d;
            step_q    <= step_d;
            state_q   <= state_d;
            changed_q <= change_s;
        end
    end

    assign seq_num     = seq_q;
    assign step_num    = step_q;
    assign rom_addr    = {seq_q, step_q};
    assign seq_changed = changed_q;

endmodule

// File: tb/tb_seq_player.sv
// Scoreboard bench for seq_player: stimulus pushes expected seq/step values,
// a negedge monitor pops them on seq_changed pulses and after each slow_tick.
module tb_seq_player;

    localparam int NUM_SEQ  = 4;
    localparam int STEPS    = 8;
    localparam int DB_DEPTH = 4;
    localparam int DB_DIV   = 4;

    logic       clk_50    = 1'b0;
    logic       reset     = 1'b0;
    logic       pb_seq_up = 1'b0;
    logic       pb_seq_dn = 1'b0;
    logic       slow_tick = 1'b0;
    logic [1:0] seq_num;
    logic [2:0] step_num;
    logic [4:0] rom_addr;
    logic       seq_changed;

    int   n_vec     = 0;
    int   n_err     = 0;
    int   pulse_cnt = 0;
    int   base;
    logic tick_at_edge = 1'b0;
    int   exp_seq[$];
    int   exp_step[$];

    always #5 clk_50 = ~clk_50;

    seq_player #(
        .NUM_SEQ  (NUM_SEQ),
        .STEPS    (STEPS),
        .DB_DEPTH (DB_DEPTH),
        .DB_DIV   (DB_DIV)
    ) dut (
        .clk_50      (clk_50),
        .reset       (reset),
        .pb_seq_up   (pb_seq_up),
        .pb_seq_dn   (pb_seq_dn),
        .slow_tick   (slow_tick),
        .seq_num     (seq_num),
        .step_num    (step_num),
        .rom_addr    (rom_addr),
        .seq_changed (seq_changed)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk_50);
        #1;
    endtask

    task automatic tick(input int exp);
        exp_step.push_back(exp);
        slow_tick = 1'b1;
        cyc(1);
        slow_tick = 1'b0;
        cyc(3);
    endtask

    task automatic press(input logic up, input logic dn);
        pb_seq_up = up;
        pb_seq_dn = dn;
        cyc(40);
        pb_seq_up = 1'b0;
        pb_seq_dn = 1'b0;
        cyc(40);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        cyc(5);
        chk("reset_seq_num", int'(seq_num), 0);
        chk("reset_step_num", int'(step_num), 0);
        chk("reset_rom_addr", int'(rom_addr), 0);
        chk("reset_seq_changed", int'(seq_changed), 0);
        reset = 1'b1;
        cyc(1);
    endtask

    always @(posedge clk_50) tick_at_edge <= slow_tick;

    // Monitor: compare DUT outputs against queued expectations.
    always @(negedge clk_50) begin
        int e;
        if (reset) begin
            if (seq_changed) begin
                pulse_cnt++;
                if (exp_seq.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL seq_changed_unexpected: got pulse with seq_num=%0d, required none (t=%0t)",
                             seq_num, $time);
                end else begin
                    e = exp_seq.pop_front();
                    chk("seq_num_on_pulse", int'(seq_num), e);
                    chk("step_zero_on_pulse", int'(step_num), 0);
                end
            end
            if (tick_at_edge) begin
                if (exp_step.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL step_unexpected_tick: got step %0d with no expectation (t=%0t)",
                             step_num, $time);
                end else begin
                    e = exp_step.pop_front();
                    chk("step_after_tick", int'(step_num), e);
                end
            end
        end
    end

    initial begin
        // Reset values and idle address
        do_reset();
        cyc(3);
        chk("idle_rom_addr", int'(rom_addr), 0);

        // Short glitch must be rejected
        pb_seq_up = 1'b1;
        cyc(10);
        pb_seq_up = 1'b0;
        cyc(40);
        chk("glitch_seq_num", int'(seq_num), 0);
        chk("glitch_pulses", pulse_cnt, 0);

        // Held press selects sequence 1
        exp_seq.push_back(1);
        press(1'b1, 1'b0);
        chk("press_seq_num", int'(seq_num), 1);
        chk("press_pulses", pulse_cnt, 1);
        chk("press_step", int'(step_num), 0);

        // Resync: first tick after a change holds step 0
        tick(0); tick(1); tick(2); tick(3); tick(4); tick(5);
        exp_seq.push_back(2);
        press(1'b1, 1'b0);
        chk("resync_step", int'(step_num), 0);
        tick(0);
        tick(1);
        chk("resync_rom_addr", int'(rom_addr), 17);

        // Top boundary: four presses from 0
        do_reset();
        base = pulse_cnt;
        exp_seq.push_back(1);
        exp_seq.push_back(2);
        exp_seq.push_back(3);
`ifdef SEQ_WRAP_EN
        exp_seq.push_back(0);
`endif
        repeat (4) press(1'b1, 1'b0);
`ifdef SEQ_WRAP_EN
        chk("boundary_seq_num", int'(seq_num), 0);
        chk("boundary_pulses", pulse_cnt - base, 4);
`else
        chk("boundary_seq_num", int'(seq_num), 3);
        chk("boundary_pulses", pulse_cnt - base, 3);
`endif
        chk("boundary_queue_empty", exp_seq.size(), 0);

        // Simultaneous up and down cancel; stepping continues
        tick(0);
        tick(1);
        base = pulse_cnt;
        press(1'b1, 1'b1);
        tick(2);
        tick(3);
`ifdef SEQ_WRAP_EN
        chk("simul_seq_num", int'(seq_num), 0);
`else
        chk("simul_seq_num", int'(seq_num), 3);
`endif
        chk("simul_pulses", pulse_cnt - base, 0);

        // Reset mid-operation with up held
        do_reset();
        exp_seq.push_back(1);
        exp_seq.push_back(2);
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        tick(0); tick(1); tick(2); tick(3); tick(4); tick(5); tick(6);
        chk("midop_pre_rom_addr", int'(rom_addr), 22);
        pb_seq_up = 1'b1;
        cyc(10);
        do_reset();
        exp_seq.push_back(1);
        cyc(40);
        pb_seq_up = 1'b0;
        cyc(40);
        chk("midop_seq_num", int'(seq_num), 1);

        cyc(5);
        chk("final_seq_queue_empty", exp_seq.size(), 0);
        chk("final_step_queue_empty", exp_step.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
